imem_serial_loader: RTL and testbench

//  Write side of the 16x16 instruction store; the PC/fetch path is the read side.

---
 rtl/imem_pkg.sv | 24 ++
 rtl/imem_shift_rx.sv | 53 +++++
 rtl/imem_serial_loader.sv | 155 +++++++++++++++
 tb/tb_imem_serial_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the 16x16 instruction store (loader and PC/fetch side).
// Optional feature macro: IMEM_LOADER_PARITY_EN (one odd-parity bit per word).
package imem_pkg;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

`ifdef IMEM_LOADER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Loader FSM encoding; PCHK is only reachable when the parity feature is built.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        PCHK   = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/imem_shift_rx.sv
// Serial receiver: MSB-first shift register, bit counter and word_ready strobe.
// With IMEM_LOADER_PARITY_EN each frame carries one extra trailing parity bit,
// and o_parity_ok reports odd parity over the whole captured frame.
module imem_shift_rx
    import imem_pkg::*;
#(
    parameter int WIDTH = imem_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_shift_en,
    input  logic             i_ser_valid,
    input  logic             i_ser_bit,
    output logic [WIDTH-1:0] o_word,
    output logic             o_word_ready
`ifdef IMEM_LOADER_PARITY_EN
    ,
    output logic             o_parity_ok
`endif
);

    localparam int NB = WIDTH + PAR_BITS;
    localparam int CW = $clog2(NB + 1);

    logic [NB-1:0] r_shreg;
    logic [CW-1:0] r_bit_cnt;
    logic          w_accept;
    logic          w_last;

    assign w_accept     = i_shift_en & i_ser_valid;
    assign w_last       = (r_bit_cnt == CW'(NB - 1));
    assign o_word_ready = w_accept & w_last;
    assign o_word       = r_shreg[NB-1 -: WIDTH];

`ifdef IMEM_LOADER_PARITY_EN
    assign o_parity_ok = ^r_shreg;
`endif

    // Shift in accepted bits; the counter wraps to zero on the last bit of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (i_clear) begin
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_shreg   <= {r_shreg[NB-2:0], i_ser_bit};
            r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_serial_loader.sv
// Write side of the instruction store: loader FSM, write pointer, memory array
// and the registered fetch read port. Optional macro: IMEM_LOADER_PARITY_EN.
module imem_serial_loader
    import imem_pkg::*;
#(
    parameter int WIDTH = imem_pkg::WIDTH,
    parameter int DEPTH = imem_pkg::DEPTH,
    parameter int AW    = imem_pkg::AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             ser_valid,
    input  logic             ser_bit,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      wr_count,
    output logic             parity_err,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    loader_state_t    r_state;
    loader_state_t    w_state_nxt;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_wr_count;
    logic [WIDTH-1:0] r_rd_data;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_clear;
    logic             w_commit;
    logic             w_busy;
    logic [WIDTH-1:0] w_word;
    logic             w_word_ready;

`ifdef IMEM_LOADER_PARITY_EN
    logic             w_parity_ok;
    logic             w_perr_nxt;
    logic             r_parity_err;
`endif

    imem_shift_rx #(.WIDTH(WIDTH)) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .i_shift_en   (r_state == SHIFT),
        .i_ser_valid  (ser_valid),
        .i_ser_bit    (ser_bit),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
`ifdef IMEM_LOADER_PARITY_EN
        ,
        .o_parity_ok  (w_parity_ok)
`endif
    );

    assign w_busy   = (r_state == SHIFT) || (r_state == PCHK) || (r_state == COMMIT);
    assign busy     = w_busy;
    assign done     = (r_state == DONE);
    assign wr_count = r_wr_count;
    assign rd_data  = r_rd_data;

`ifdef IMEM_LOADER_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    // Next-state logic; load_start is only honoured from IDLE or DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_commit    = 1'b0;
`ifdef IMEM_LOADER_PARITY_EN
        w_perr_nxt  = 1'b0;
`endif
        case (r_state)
            IDLE, DONE: begin
                if (load_start) begin
                    w_state_nxt = SHIFT;
                    w_clear     = 1'b1;
                end
            end
            SHIFT: begin
                if (w_word_ready) begin
`ifdef IMEM_LOADER_PARITY_EN
                    w_state_nxt = PCHK;
`else
                    w_state_nxt = COMMIT;
`endif
                end
            end
`ifdef IMEM_LOADER_PARITY_EN
            PCHK: begin
                if (w_parity_ok) begin
                    w_state_nxt = COMMIT;
                end else begin
                    w_state_nxt = SHIFT;
                    w_perr_nxt  = 1'b1;
                end
            end
`endif
            COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = (r_wr_ptr == AW'(DEPTH - 1)) ? DONE : SHIFT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, write pointer and committed-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_wr_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_wr_ptr   <= '0;
                r_wr_count <= '0;
            end else if (w_commit) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_wr_count <= r_wr_count + 1'b1;
            end
        end
    end

`ifdef IMEM_LOADER_PARITY_EN
    // One-cycle pulse when a word fails the odd-parity check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_perr_nxt;
        end
    end
`endif

    // Memory array write; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Fetch port: registered read, frozen while a load is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (!w_busy) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_imem_serial_loader.sv
// Self-checking bench for imem_serial_loader with a behavioural memory model.
// Honours IMEM_LOADER_PARITY_EN when defined at compile time.
module tb_imem_serial_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic        ser_valid;
    logic        ser_bit;
    logic        busy;
    logic        done;
    logic [4:0]  wr_count;
    logic        parity_err;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;

    int unsigned n_vec;
    int unsigned n_err;
    logic [15:0] ref_mem [16];

    imem_serial_loader #(.WIDTH(16), .DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .ser_valid  (ser_valid),
        .ser_bit    (ser_bit),
        .busy       (busy),
        .done       (done),
        .wr_count   (wr_count),
        .parity_err (parity_err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    function automatic logic good_par(input logic [15:0] w);
        return ~(^w);
    endfunction

    // Send one word (plus parity bit when built). mode 0: back-to-back,
    // 1: valid toggles every cycle, 2: random gaps. Returns after the commit
    // cycle; perr is parity_err observed in the cycle after the check.
    task automatic send_word(input logic [15:0] w, input logic par, input int mode,
                             output logic perr);
        logic [16:0] fr;
        int nb;
`ifdef IMEM_LOADER_PARITY_EN
        fr = {w, par};
        nb = 17;
`else
        fr = {1'b0, w};
        nb = 16;
`endif
        for (int i = nb - 1; i >= 0; i--) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0)) begin
                ser_valid = 1'b0;
                ser_bit   = 1'($urandom_range(0, 1));
                tick();
            end
            ser_valid = 1'b1;
            ser_bit   = fr[i];
            tick();
        end
        ser_valid = 1'b0;
        tick();
        perr = parity_err;
`ifdef IMEM_LOADER_PARITY_EN
        tick();
`endif
    endtask

    task automatic send_checked(input int idx, input logic [15:0] w, input int mode);
        logic perr;
        send_word(w, good_par(w), mode, perr);
        ref_mem[idx] = w;
        n_vec++;
        if (wr_count !== 5'(idx + 1) || perr !== 1'b0) begin
            n_err++;
            $display("FAIL word_commit[%0d]: wr_count=%0d perr=%b, want wr_count=%0d perr=0",
                     idx, wr_count, perr, idx + 1);
        end
    endtask

    task automatic check_done();
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_count !== 5'd16) begin
            n_err++;
            $display("FAIL load_done: done=%b busy=%b wr_count=%0d, want 1 0 16",
                     done, busy, wr_count);
        end
    endtask

    task automatic sweep_read();
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            n_vec++;
            if (rd_data !== ref_mem[a]) begin
                n_err++;
                $display("FAIL read[%0d]: rd_data=%h, want %h", a, rd_data, ref_mem[a]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_start = 1'b0; ser_valid = 1'b0; ser_bit = 1'b0; rd_addr = '0;
        repeat (3) tick();
        n_vec++;
        if ({busy, done, wr_count, parity_err, rd_data} !== 24'h0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b wr_count=%0d perr=%b rd_data=%h, want all 0",
                     busy, done, wr_count, parity_err, rd_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sequential_load();
        pulse_start();
        for (int i = 0; i < 16; i++) send_checked(i, 16'(i), 0);
        check_done();
        sweep_read();
    endtask

    task automatic test_valid_toggle();
        pulse_start();
        send_checked(0, 16'hA5C3, 1);
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL toggle_busy: busy=%b done=%b, want 1 0", busy, done);
        end
        for (int i = 1; i < 16; i++) send_checked(i, 16'($urandom), 2);
        check_done();
        sweep_read();
    endtask

    task automatic test_read_hold();
        logic [15:0] held;
        rd_addr = 4'($urandom_range(0, 15));
        held = ref_mem[rd_addr];
        tick();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'($urandom_range(0, 15));
            send_checked(i, 16'($urandom), 2);
            n_vec++;
            if (i < 15 && rd_data !== held) begin
                n_err++;
                $display("FAIL read_hold[%0d]: rd_data=%h, want %h", i, rd_data, held);
            end
        end
        check_done();
        sweep_read();
    endtask

    task automatic test_restart_ignored();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            send_checked(i, 16'($urandom), 0);
            if (i == 6) begin
                load_start = 1'b1;
                tick();
                load_start = 1'b0;
                n_vec++;
                if (wr_count !== 5'd7 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL start_ignored: wr_count=%0d busy=%b, want 7 1",
                             wr_count, busy);
                end
            end
        end
        check_done();
        sweep_read();
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        for (int i = 0; i < 5; i++) send_checked(i, 16'($urandom), 0);
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({busy, done, wr_count, parity_err, rd_data} !== 24'h0) begin
            n_err++;
            $display("FAIL mid_reset: busy=%b done=%b wr_count=%0d perr=%b rd_data=%h, want all 0",
                     busy, done, wr_count, parity_err, rd_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        for (int i = 0; i < 16; i++) send_checked(i, 16'hFFFF, 2);
        check_done();
        sweep_read();
    endtask

`ifdef IMEM_LOADER_PARITY_EN
    task automatic test_parity();
        logic perr;
        pulse_start();
        send_word(16'h0001, 1'b1, 0, perr);
        n_vec++;
        if (perr !== 1'b1 || wr_count !== 5'd0 || parity_err !== 1'b0) begin
            n_err++;
            $display("FAIL parity_reject: pulse=%b wr_count=%0d after=%b, want 1 0 0",
                     perr, wr_count, parity_err);
        end
        send_checked(0, 16'h0001, 0);
        for (int i = 1; i < 16; i++) send_checked(i, 16'($urandom), 2);
        check_done();
        sweep_read();
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_sequential_load();
        test_valid_toggle();
        test_read_hold();
        test_restart_ignored();
        test_reset_mid_load();
`ifdef IMEM_LOADER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
